// File: rtl/addsub_rr_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | addsub_rr_sched_if : requester/consumer bundle for addsub_rr_sched    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface addsub_rr_sched_if #(
    parameter int N = 4
);
    logic                req0;
    logic [N-1:0]        a0;
    logic [N-1:0]        b0;
    logic                op0;
    logic                gnt0;
    logic                req1;
    logic [N-1:0]        a1;
    logic [N-1:0]        b1;
    logic                op1;
    logic                gnt1;
    logic                out_valid;
    logic                out_ready;
    logic                out_id;
    logic signed [N:0]   result;
    logic                sat;
    logic                busy;

    modport slave (
        input  req0, a0, b0, op0, req1, a1, b1, op1, out_ready,
        output gnt0, gnt1, out_valid, out_id, result, sat, busy
    );

    modport master (
        output req0, a0, b0, op0, req1, a1, b1, op1, out_ready,
        input  gnt0, gnt1, out_valid, out_id, result, sat, busy
    );
endinterface
`default_nettype wire

// File: rtl/addsub_rr_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | addsub_rr_sched : two-requester round-robin shared add/sub unit.      |
// | ADDSUB_RR_SCHED_SAT_EN clamps results to N bits. Revision: 1.0        |
// +----------------------------------------------------------------------+
module addsub_rr_sched #(
    parameter int N = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    addsub_rr_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_ptr;
    logic [N-1:0]        r_a;
    logic [N-1:0]        r_b;
    logic                r_op;
    logic                r_id;
    logic signed [N:0]   r_result;
    logic                r_out_id;
    logic                r_sat;
    logic                r_out_valid;
    logic                w_gnt0;
    logic                w_gnt1;
    logic signed [N:0]   w_a_ext;
    logic signed [N:0]   w_b_ext;
    logic signed [N:0]   w_exact;
    logic signed [N:0]   w_res;
    logic                w_sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grants are gated by rst so they read 0 while reset is held.
    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (!rst) begin
                    if (bus.req0 && !(bus.req1 && r_ptr)) begin
                        w_gnt0 = 1'b1;
                    end else if (bus.req1) begin
                        w_gnt1 = 1'b1;
                    end
                end
                if (w_gnt0 || w_gnt1) begin
                    w_state_nxt = EXEC;
                end
            end
            EXEC: w_state_nxt = DONE;
            DONE: begin
                if (r_out_valid && bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_a_ext = $signed({r_a[N-1], r_a});
    assign w_b_ext = $signed({r_b[N-1], r_b});
    assign w_exact = r_op ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);

`ifdef ADDSUB_RR_SCHED_SAT_EN
    localparam logic signed [N:0] c_sat_max = $signed({2'b00, {(N-1){1'b1}}});
    localparam logic signed [N:0] c_sat_min = $signed({2'b11, {(N-1){1'b0}}});

    always_comb begin
        w_res = w_exact;
        w_sat = 1'b0;
        if (w_exact > c_sat_max) begin
            w_res = c_sat_max;
            w_sat = 1'b1;
        end else if (w_exact < c_sat_min) begin
            w_res = c_sat_min;
            w_sat = 1'b1;
        end
    end
`else
    assign w_res = w_exact;
    assign w_sat = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= 1'b0;
            r_id        <= 1'b0;
            r_result    <= '0;
            r_out_id    <= 1'b0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_gnt0 || w_gnt1) begin
                r_a   <= w_gnt1 ? bus.a1  : bus.a0;
                r_b   <= w_gnt1 ? bus.b1  : bus.b0;
                r_op  <= w_gnt1 ? bus.op1 : bus.op0;
                r_id  <= w_gnt1;
                r_ptr <= ~w_gnt1;
            end
            if (r_state == EXEC) begin
                r_result    <= w_res;
                r_sat       <= w_sat;
                r_out_id    <= r_id;
                r_out_valid <= 1'b1;
            end else if (r_state == DONE && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.gnt0      = w_gnt0;
    assign bus.gnt1      = w_gnt1;
    assign bus.out_valid = r_out_valid;
    assign bus.out_id    = r_out_id;
    assign bus.result    = r_result;
    assign bus.sat       = r_sat;
    assign bus.busy      = (r_state != IDLE);
endmodule
`default_nettype wire

// File: doc/addsub_rr_sched.md
Name: addsub_rr_sched

Overview:
- Round-robin scheduler that shares one signed n-bit add/sub datapath between two requesters.
- Each request carries its own operands and an add/sub opcode.
- The block arbitrates, latches the operands, runs one execute cycle, then holds a tagged (n+1)-bit signed result until the consumer accepts it.
- It sits between the requester front-ends and the shared arithmetic unit in the ALU datapath.

Parameters:
- n, 4: operand width in bits (two's complement); result width is n+1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req0  input  1  requester 0 request; held high with operands stable until gnt0
- a0  input  n  requester 0 operand a, signed
- b0  input  n  requester 0 operand b, signed
- op0  input  1  requester 0 opcode: 0 = a+b, 1 = a-b
- gnt0  output  1  one-cycle pulse: requester 0 operands latched this edge
- req1  input  1  requester 1 request
- a1  input  n  requester 1 operand a, signed
- b1  input  n  requester 1 operand b, signed
- op1  input  1  requester 1 opcode
- gnt1  output  1  one-cycle pulse for requester 1
- out_valid  output  1  result/out_id/sat valid
- out_ready  input  1  consumer accepts result when high with out_valid
- out_id  output  1  id of the requester that owns the result
- result  output  n+1  signed result
- sat  output  1  saturation flag (optional feature)
- busy  output  1  high in EXEC or DONE

Behaviour:
- Reset (asynchronous, any state): state=IDLE; gnt0=gnt1=0; out_valid=0; out_id=0; result=0; sat=0; busy=0; rr pointer=0 (requester 0 preferred first).
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - No request pending: stay in IDLE, all gnt=0.
  - Exactly one request pending: grant it.
  - Both pending: grant the requester named by the rr pointer.
  - On grant: assert gnt for that requester for that cycle only (combinational from state/req/pointer); capture a, b, op and id at the edge; flip the pointer to the other requester; go to EXEC.
- EXEC (1 cycle): compute using the latched operands.
  - Sign-extend a and b to n+1 bits, then compute a+b or a-b.
  - The result is always exact in n+1 bits, including b = -2^(n-1) for subtract.
  - Register result and out_id; set out_valid=1; go to DONE.
- DONE:
  - Hold result, out_id, sat and out_valid stable.
  - While out_ready=0: no grants; requests stay pending.
  - On out_valid & out_ready: clear out_valid; go to IDLE.
  - result and out_id keep their last value after acceptance.
- Latency: grant edge T → out_valid high from edge T+2. Minimum spacing between grants is 3 cycles.
- Requests dropped before grant are simply not served; there is no error flag.
- A request that is high during EXEC/DONE is granted at the next IDLE.
- rst during EXEC or DONE aborts the operation immediately. The in-flight result is discarded and the requester is not re-granted unless it still requests.
- busy = (state != IDLE).

Optional Feature:
- Macro: ADDSUB_RR_SCHED_SAT_EN.
- Defined:
  - At EXEC, clamp the exact result to the n-bit signed range [-2^(n-1), 2^(n-1)-1], sign-extended into the n+1-bit result.
  - sat=1 when clamping occurred, else 0; sat is registered alongside result.
- Undefined:
  - result is the exact n+1-bit value.
  - sat is tied to 0.
  - No clamp logic is built.

Test Plan (n=4):
- Reset check: assert rst mid-run → all outputs 0 and state IDLE immediately, without waiting for a clock edge. Then raise req1 alone → gnt1 pulses, out_id=1.
- Subtract: req0 with a0=3, b0=-5, op0=1 → gnt0 at T; out_valid at T+2; result=5'sd8; out_id=0; sat=0.
- Edge case (macro off): a0=7, b0=-8, op0=1 → result=5'sd15. Then a0=-8, b0=-8, op0=0 → result=-16 (5'b10000).
- Arbitration: req0 and req1 both held high after reset, out_ready=1 → grants go 0,1,0,1 with 3-cycle spacing; out_id matches each grant.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with req1 high → result/out_id stable, no gnt. Raise out_ready → out_valid drops next edge, and gnt1 pulses the following cycle.
- With ADDSUB_RR_SCHED_SAT_EN: a=7, b=1, add → result=7, sat=1. a=-8, b=1, subtract → result=-8, sat=1. a=2, b=3, add → result=5, sat=0.
